// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types, widths and the restoring-division step for the pipelined divider
//
// Purpose : one place for the default divider geometry, the per-stage register
//           layout (t_div_stage) and div_step(), the single restoring step that
//           every stage repeats BITS_PER_STAGE times.
// Ports   : none (package).
package divider_pkg;

  localparam int DIV_DATA_LEN       = 32;
  localparam int DIV_PIPELINE_STAGE = 16;
  localparam int BITS_PER_STAGE     = DIV_DATA_LEN / DIV_PIPELINE_STAGE;

  typedef logic [DIV_DATA_LEN-1:0] t_data;
  typedef logic [DIV_DATA_LEN:0]   t_rem;

  // dq starts as the dividend magnitude and is shifted left once per step;
  // quotient bits enter at the LSB, so after DATA_LEN steps it is the quotient.
  typedef struct packed {
    logic  valid;
    logic  dbz;
    t_data divisor;
    t_rem  rem;
    t_data dq;
  } t_div_stage;

  typedef struct packed {
    t_rem rem;
    logic qbit;
  } t_step;

  // rem_lo is the previous partial remainder, which is always below the divisor
  // and therefore fits in DATA_LEN bits; the shifted value needs one extra bit.
  function automatic t_step div_step(input t_data rem_lo, input logic dbit, input t_data divisor);
    t_step res;
    t_rem  shifted;
    shifted = {rem_lo, dbit};
    if (shifted >= {1'b0, divisor}) begin
      res.rem  = shifted - {1'b0, divisor};
      res.qbit = 1'b1;
    end else begin
      res.rem  = shifted;
      res.qbit = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/divider_stage.sv
// rtl/divider_stage.sv - one register stage of the pipelined divider
//
// Purpose : applies STEPS restoring-division steps to the incoming stage record
//           and registers the result. Flush clears only the valid bit.
// Ports   : clk       - rising-edge clock
//           reset_n   - asynchronous active-low reset, clears the whole record
//           flush     - synchronous drop of the op entering this stage
//           stage_in  - record from the previous stage (or the operand capture)
//           stage_out - registered record for the next stage
module divider_stage
  import divider_pkg::*;
#(
  parameter int STEPS = BITS_PER_STAGE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  t_div_stage stage_in,
  output t_div_stage stage_out
);

  t_div_stage stage_d;
  t_div_stage stage_q;
  t_div_stage cur;
  t_step      step;

  always_comb begin
    cur  = stage_in;
    step = '0;
    for (int i = 0; i < STEPS; i++) begin
      step    = div_step(cur.rem[DIV_DATA_LEN-1:0], cur.dq[DIV_DATA_LEN-1], cur.divisor);
      cur.rem = step.rem;
      cur.dq  = {cur.dq[DIV_DATA_LEN-2:0], step.qbit};
    end
    stage_d       = cur;
    stage_d.valid = stage_in.valid & ~flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_out = stage_q;

endmodule

// File: rtl/pipelined_divider_core.sv
// rtl/pipelined_divider_core.sv - fully pipelined integer divider, one op per cycle, fixed latency
//
// Purpose : divides a by b with a latency of exactly PIPELINE_STAGE cycles and
//           no backpressure. b == 0 yields quotient all-ones, remainder a.
//           Macro DIVIDER_SIGNED_EN selects two's-complement operands
//           (truncating division); without it the core is purely unsigned.
// Ports   : clk, reset_n (async active-low), flush (sync valid clear),
//           in_valid/a/b (operands), out_valid/quotient/remainder/div_by_zero
//           (registered result, held while out_valid is low),
//           busy (any stage holds a valid op).
module pipelined_divider_core
  import divider_pkg::*;
#(
  parameter int DATA_LEN       = DIV_DATA_LEN,
  parameter int PIPELINE_STAGE = DIV_PIPELINE_STAGE
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] quotient,
  output logic [DATA_LEN-1:0] remainder,
  output logic                div_by_zero,
  output logic                busy
);

  localparam int STEPS = DATA_LEN / PIPELINE_STAGE;

  if (DATA_LEN % PIPELINE_STAGE != 0) begin : g_bad_split
    $error("pipelined_divider_core: DATA_LEN must be a multiple of PIPELINE_STAGE");
  end
  if (DATA_LEN != DIV_DATA_LEN) begin : g_bad_width
    $error("pipelined_divider_core: DATA_LEN must match divider_pkg::DIV_DATA_LEN");
  end

  t_div_stage stage0_in;
  t_div_stage chain_out [PIPELINE_STAGE];
  t_div_stage last;
  t_data      a_mag;
  t_data      b_mag;
  t_data      q_res;
  t_data      r_res;

  logic  out_valid_d, out_valid_q;
  logic  dbz_d, dbz_q;
  t_data quotient_d, quotient_q;
  t_data remainder_d, remainder_q;

  assign last = chain_out[PIPELINE_STAGE-1];

`ifdef DIVIDER_SIGNED_EN
  // Sign decisions travel beside the stages so they line up with the result.
  // A zero divisor never negates the quotient, keeping it at -1.
  logic [PIPELINE_STAGE-1:0] neg_q_d, neg_q_q;
  logic [PIPELINE_STAGE-1:0] neg_r_d, neg_r_q;

  always_comb begin
    a_mag      = a[DATA_LEN-1] ? -a : a;
    b_mag      = b[DATA_LEN-1] ? -b : b;
    neg_q_d    = neg_q_q << 1;
    neg_q_d[0] = (a[DATA_LEN-1] ^ b[DATA_LEN-1]) & (b != '0);
    neg_r_d    = neg_r_q << 1;
    neg_r_d[0] = a[DATA_LEN-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_q_q <= '0;
      neg_r_q <= '0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

  // MIN / -1 needs no special case: the magnitude quotient 2^(N-1) is
  // left un-negated and reads back as MIN.
  always_comb begin
    q_res = neg_q_q[PIPELINE_STAGE-1] ? -last.dq : last.dq;
    r_res = neg_r_q[PIPELINE_STAGE-1] ? -last.rem[DATA_LEN-1:0] : last.rem[DATA_LEN-1:0];
  end
`else
  always_comb begin
    a_mag = a;
    b_mag = b;
    q_res = last.dq;
    r_res = last.rem[DATA_LEN-1:0];
  end
`endif

  always_comb begin
    stage0_in         = '0;
    stage0_in.valid   = in_valid;
    stage0_in.dbz     = (b == '0);
    stage0_in.divisor = b_mag;
    stage0_in.dq      = a_mag;
  end

  for (genvar k = 0; k < PIPELINE_STAGE; k++) begin : g_stage
    if (k == 0) begin : g_first
      divider_stage #(.STEPS(STEPS)) u_stage (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .stage_in  (stage0_in),
        .stage_out (chain_out[k])
      );
    end else begin : g_next
      divider_stage #(.STEPS(STEPS)) u_stage (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .stage_in  (chain_out[k-1]),
        .stage_out (chain_out[k])
      );
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < PIPELINE_STAGE; k++) begin
      busy = busy | chain_out[k].valid;
    end
  end

  always_comb begin
    out_valid_d = last.valid & ~flush;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (out_valid_d) begin
      quotient_d  = q_res;
      remainder_d = r_res;
      dbz_d       = last.dbz;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

  // The final divisor and the remainder guard bit are not needed at the output.
  logic unused_last;
  assign unused_last = ^{last.divisor, last.rem[DATA_LEN]};

endmodule

// File: tb/tb_pipelined_divider_core.sv
// tb/tb_pipelined_divider_core.sv - directed and random self-checking bench for pipelined_divider_core
module tb_pipelined_divider_core;

  localparam int W = 32;
  localparam int P = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic         rv_vld [3100];
  logic [W-1:0] rv_a   [3100];
  logic [W-1:0] rv_b   [3100];

  always #5 clk = ~clk;

  pipelined_divider_core #(.DATA_LEN(W), .PIPELINE_STAGE(P)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    dz = (y == '0);
    if (y == '0) begin
      q = '1;
      r = x;
    end
`ifdef DIVIDER_SIGNED_EN
    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = x;
      r = '0;
    end else begin
      q = 32'($signed(x) / $signed(y));
      r = 32'($signed(x) % $signed(y));
    end
`else
    else begin
      q = x / y;
      r = x % y;
    end
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    a = 32'd100; b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_start: got %b want 1", busy); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'(k == P)) begin errors++; $display("FAIL single_out_valid cycle %0d: got %b want %b", k, out_valid, k == P); end
      if (k == P) begin
        checks++;
        if ({quotient, remainder, div_by_zero} !== {32'd14, 32'd2, 1'b0}) begin
          errors++; $display("FAIL single_result: got q=%0d r=%0d dbz=%b want q=14 r=2 dbz=0", quotient, remainder, div_by_zero);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
      end
    end
  endtask

  task automatic test_reset_mid_flight();
    for (int k = 0; k < 4; k++) begin
      a = 32'(1000 + k); b = 32'd3; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL midrst_hold_quotient: got %0d want 14", quotient); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++;
    if ({quotient, remainder, div_by_zero} !== 65'd0) begin
      errors++; $display("FAIL midrst_outputs: got q=%h r=%h dbz=%b want all 0", quotient, remainder, div_by_zero);
    end
    tick();
    reset_n = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      in_valid = (k == 0); a = 32'd1000; b = 32'd3;
      tick();
      checks++;
      if (out_valid !== 1'(k == P)) begin errors++; $display("FAIL midrst_after_out_valid cycle %0d: got %b want %b", k, out_valid, k == P); end
      if (k == P) begin
        checks++;
        if ({quotient, remainder, div_by_zero} !== {32'd333, 32'd1, 1'b0}) begin
          errors++; $display("FAIL midrst_after_result: got q=%0d r=%0d dbz=%b want q=333 r=1 dbz=0", quotient, remainder, div_by_zero);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 30; k++) begin
      in_valid = (k < 5); flush = (k == 4); a = 32'(50 + k); b = 32'd3;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid cycle %0d: got %b want 0", k, out_valid); end
      if (k == 3) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b want 1", busy); end
      end
      if (k == 4) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b want 0", busy); end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_boundaries();
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic [W-1:0] eq [5];
    logic [W-1:0] er [5];
    logic         ed [5];
    int           j;
    logic         exp_v;
    va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd77, 32'd0};
    vb = '{32'd0,         32'd1,         32'd9, 32'd77, 32'd3};
    eq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1,  32'd0};
    er = '{32'hFFFF_FFFF, 32'd0,         32'd5, 32'd0,  32'd0};
    ed = '{1'b1,          1'b0,          1'b0,  1'b0,   1'b0};
    for (int k = 0; k < 24; k++) begin
      in_valid = (k < 5);
      if (k < 5) begin a = va[k]; b = vb[k]; end
      tick();
      j = k - P;
      exp_v = (j >= 0 && j < 5);
      checks++;
      if (out_valid !== exp_v) begin errors++; $display("FAIL bound_out_valid cycle %0d: got %b want %b", k, out_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if ({quotient, remainder, div_by_zero} !== {eq[j], er[j], ed[j]}) begin
          errors++; $display("FAIL bound_result %0d: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                             j, quotient, remainder, div_by_zero, eq[j], er[j], ed[j]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [20];
    logic [W-1:0] vb [20];
    logic [W-1:0] eq, er;
    logic         ed, exp_v;
    int           j;
    for (int k = 0; k < 40; k++) begin
      in_valid = (k < 20);
      if (k < 20) begin
        va[k] = $urandom; vb[k] = (k % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
        a = va[k]; b = vb[k];
      end
      tick();
      j = k - P;
      exp_v = (j >= 0 && j < 20);
      checks++;
      if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_out_valid cycle %0d: got %b want %b", k, out_valid, exp_v); end
      if (exp_v) begin
        ref_div(va[j], vb[j], eq, er, ed);
        checks++;
        if ({quotient, remainder, div_by_zero} !== {eq, er, ed}) begin
          errors++; $display("FAIL b2b_result %0d: a=%h b=%h got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                             j, va[j], vb[j], quotient, remainder, div_by_zero, eq, er, ed);
        end
      end
    end
  endtask

  task automatic test_random();
    int           issued = 0;
    int           seen = 0;
    int           last_k = 0;
    int           sel;
    logic [W-1:0] x, y, t, eq, er;
    logic         ed, exp_v;
    for (int k = 0; k < 3100; k++) begin
      rv_vld[k] = 1'b0;
      if (issued < 1000 && $urandom_range(0, 3) != 0) begin
        x = $urandom; y = $urandom; sel = $urandom_range(0, 7);
        case (sel)
          0: y = '0;
          1: if (x > y) begin t = x; x = y; y = t; end
          2: y = 32'($urandom_range(1, 255));
          3: y = 32'd1;
          default: ;
        endcase
        rv_vld[k] = 1'b1; rv_a[k] = x; rv_b[k] = y;
        issued++; last_k = k;
      end
      in_valid = rv_vld[k]; a = rv_a[k]; b = rv_b[k];
      tick();
      exp_v = (k >= P) ? rv_vld[k-P] : 1'b0;
      checks++;
      if (out_valid !== exp_v) begin errors++; $display("FAIL rand_out_valid cycle %0d: got %b want %b", k, out_valid, exp_v); end
      if (out_valid === 1'b1) seen++;
      if (exp_v) begin
        ref_div(rv_a[k-P], rv_b[k-P], eq, er, ed);
        checks++;
        if ({quotient, remainder, div_by_zero} !== {eq, er, ed}) begin
          errors++; $display("FAIL rand_result cycle %0d: a=%h b=%h got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                             k, rv_a[k-P], rv_b[k-P], quotient, remainder, div_by_zero, eq, er, ed);
        end
      end
      if (issued == 1000 && k >= last_k + P + 2) break;
    end
    in_valid = 1'b0;
    checks++;
    if (seen != 1000) begin errors++; $display("FAIL rand_result_count: got %0d want 1000", seen); end
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W-1:0] eq [4];
    logic [W-1:0] er [4];
    logic         ed [4];
    int           j;
    logic         exp_v;
    va = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7,        32'hFFFF_FFF9};
    vb = '{32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};
    eq = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    er = '{32'hFFFF_FFFF, 32'd0,         32'd1,         32'hFFFF_FFF9};
    ed = '{1'b0,          1'b0,          1'b0,          1'b1};
    for (int k = 0; k < 22; k++) begin
      in_valid = (k < 4);
      if (k < 4) begin a = va[k]; b = vb[k]; end
      tick();
      j = k - P;
      exp_v = (j >= 0 && j < 4);
      checks++;
      if (out_valid !== exp_v) begin errors++; $display("FAIL signed_out_valid cycle %0d: got %b want %b", k, out_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if ({quotient, remainder, div_by_zero} !== {eq[j], er[j], ed[j]}) begin
          errors++; $display("FAIL signed_result %0d: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                             j, quotient, remainder, div_by_zero, eq[j], er[j], ed[j]);
        end
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_reset_mid_flight();
    test_flush();
    test_boundaries();
    test_back_to_back();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
